// File: rtl/axil_data_mem.sv
// rtl/axil_data_mem.sv - AXI4-Lite responder word memory with byte strobes and wait states
// One transaction at a time; writes take priority over a simultaneous read.
module axil_data_mem #(
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int          DEPTH_WORDS = 1024,
  parameter int          WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        nreset,
  input  logic        awvalid,
  output logic        awready,
  input  logic [31:0] awaddr,
  input  logic        wvalid,
  output logic        wready,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  output logic        bvalid,
  input  logic        bready,
  output logic [1:0]  bresp,
  input  logic        arvalid,
  output logic        arready,
  input  logic [31:0] araddr,
  output logic        rvalid,
  input  logic        rready,
  output logic [31:0] rdata,
  output logic [1:0]  rresp
);
  localparam int         IW          = $clog2(DEPTH_WORDS);
  localparam logic [2:0] WS          = 3'(WAIT_STATES);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [2:0] ST_IDLE       = 3'd0;
  localparam logic [2:0] ST_WR_COLLECT = 3'd1;
  localparam logic [2:0] ST_WR_WAIT    = 3'd2;
  localparam logic [2:0] ST_WR_RESP    = 3'd3;
  localparam logic [2:0] ST_RD_WAIT    = 3'd4;
  localparam logic [2:0] ST_RD_RESP    = 3'd5;

  logic [2:0]  state_q, state_d;
  logic        aw_got_q, aw_got_d;
  logic        w_got_q, w_got_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [1:0]  bresp_q, bresp_d;
  logic [1:0]  rresp_q, rresp_d;
  logic [31:0] rdata_q, rdata_d;

  logic [31:0] mem [DEPTH_WORDS];

  logic [31:0]   off;
  logic [IW-1:0] idx;
  logic          in_range;
  logic          mem_we;
  logic          aw_hs, w_hs, ar_hs;
  logic          unused_off;

  // Offset wraps in 32 bits, so addresses below BASE_ADDR land far out of range.
  assign off        = addr_q - BASE_ADDR;
  assign idx        = off[IW+1:2];
  assign in_range   = (off[31:IW+2] == '0);
  assign unused_off = ^off[1:0];

  assign awready = ((state_q == ST_IDLE) || (state_q == ST_WR_COLLECT)) && !aw_got_q;
  assign wready  = ((state_q == ST_IDLE) || (state_q == ST_WR_COLLECT)) && !w_got_q;
  assign arready = (state_q == ST_IDLE) && !awvalid && !wvalid;

  assign aw_hs = awvalid && awready;
  assign w_hs  = wvalid && wready;
  assign ar_hs = arvalid && arready;

  assign bvalid = (state_q == ST_WR_RESP);
  assign rvalid = (state_q == ST_RD_RESP);
  assign bresp  = bresp_q;
  assign rresp  = rresp_q;
  assign rdata  = rdata_q;

  // The memory update coincides with the WR_WAIT -> WR_RESP transition.
  assign mem_we = (state_q == ST_WR_WAIT) && (cnt_q == WS) && in_range;

  always_comb begin
    state_d  = state_q;
    aw_got_d = aw_got_q;
    w_got_d  = w_got_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    wstrb_d  = wstrb_q;
    cnt_d    = cnt_q;
    bresp_d  = bresp_q;
    rresp_d  = rresp_q;
    rdata_d  = rdata_q;
    case (state_q)
      ST_IDLE, ST_WR_COLLECT: begin
        if (aw_hs) begin
          aw_got_d = 1'b1;
          addr_d   = awaddr;
        end
        if (w_hs) begin
          w_got_d = 1'b1;
          wdata_d = wdata;
          wstrb_d = wstrb;
        end
        if (aw_got_d && w_got_d) begin
          state_d  = ST_WR_WAIT;
          cnt_d    = 3'd0;
          aw_got_d = 1'b0;
          w_got_d  = 1'b0;
        end else if (aw_got_d || w_got_d) begin
          state_d = ST_WR_COLLECT;
        end else if (ar_hs) begin
          state_d = ST_RD_WAIT;
          addr_d  = araddr;
          cnt_d   = 3'd0;
        end
      end
      ST_WR_WAIT: begin
        if (cnt_q == WS) begin
          state_d = ST_WR_RESP;
          bresp_d = in_range ? RESP_OKAY : RESP_SLVERR;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      ST_WR_RESP: begin
        if (bready) state_d = ST_IDLE;
      end
      ST_RD_WAIT: begin
        if (cnt_q == WS) begin
          state_d = ST_RD_RESP;
          rresp_d = in_range ? RESP_OKAY : RESP_SLVERR;
          rdata_d = in_range ? mem[idx] : 32'h0;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      ST_RD_RESP: begin
        if (rready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q  <= ST_IDLE;
      aw_got_q <= 1'b0;
      w_got_q  <= 1'b0;
      addr_q   <= 32'h0;
      wdata_q  <= 32'h0;
      wstrb_q  <= 4'h0;
      cnt_q    <= 3'd0;
      bresp_q  <= RESP_OKAY;
      rresp_q  <= RESP_OKAY;
      rdata_q  <= 32'h0;
    end else begin
      state_q  <= state_d;
      aw_got_q <= aw_got_d;
      w_got_q  <= w_got_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      wstrb_q  <= wstrb_d;
      cnt_q    <= cnt_d;
      bresp_q  <= bresp_d;
      rresp_q  <= rresp_d;
      rdata_q  <= rdata_d;
    end
  end

  // Storage has no reset; an aborted write never reaches mem_we.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (wstrb_q[i]) mem[idx][8*i +: 8] <= wdata_q[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_axil_data_mem.sv
// tb/tb_axil_data_mem.sv - directed bench for axil_data_mem at zero and two wait states
// Two instances share stimulus data; each has its own valids and its own transaction model.
module tb_axil_data_mem;
  localparam logic [31:0] BASE  = 32'h8000_0000;
  localparam int          DEPTH = 1024;
  localparam int          WS0   = 0;
  localparam int          WS1   = 2;

  logic        clk = 1'b0;
  logic        nreset = 1'b0;
  logic [31:0] awaddr, wdata, araddr;
  logic [3:0]  wstrb;
  logic [1:0]  awvalid_v, wvalid_v, arvalid_v;
  logic        bready, rready;

  wire [1:0]       awready_v, wready_v, arready_v, bvalid_v, rvalid_v;
  wire [1:0][1:0]  bresp_v, rresp_v;
  wire [1:0][31:0] rdata_v;

  always #5 clk = ~clk;

  axil_data_mem #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH), .WAIT_STATES(WS0)) u_dut0 (
    .clk(clk), .nreset(nreset),
    .awvalid(awvalid_v[0]), .awready(awready_v[0]), .awaddr(awaddr),
    .wvalid(wvalid_v[0]), .wready(wready_v[0]), .wdata(wdata), .wstrb(wstrb),
    .bvalid(bvalid_v[0]), .bready(bready), .bresp(bresp_v[0]),
    .arvalid(arvalid_v[0]), .arready(arready_v[0]), .araddr(araddr),
    .rvalid(rvalid_v[0]), .rready(rready), .rdata(rdata_v[0]), .rresp(rresp_v[0])
  );

  axil_data_mem #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH), .WAIT_STATES(WS1)) u_dut1 (
    .clk(clk), .nreset(nreset),
    .awvalid(awvalid_v[1]), .awready(awready_v[1]), .awaddr(awaddr),
    .wvalid(wvalid_v[1]), .wready(wready_v[1]), .wdata(wdata), .wstrb(wstrb),
    .bvalid(bvalid_v[1]), .bready(bready), .bresp(bresp_v[1]),
    .arvalid(arvalid_v[1]), .arready(arready_v[1]), .araddr(araddr),
    .rvalid(rvalid_v[1]), .rready(rready), .rdata(rdata_v[1]), .rresp(rresp_v[1])
  );

  int n_pass = 0;
  int n_tot  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
    else n_pass++;
  endtask

  function automatic int ws(input int d);
    return (d == 0) ? WS0 : WS1;
  endfunction

  function automatic bit in_rng(input logic [31:0] a);
    logic [31:0] o;
    o = a - BASE;
    return o < 32'(4 * DEPTH);
  endfunction

  // Transaction model: ph 0 idle, 1 collecting, 2 write issued, 3 read issued.
  // A response becomes visible after edge vis = handshake edge + 1 + wait states.
  int          cyc = 0;
  int          ph [2];
  bit          agot [2], wgot [2];
  logic [31:0] maddr [2], mdata [2], mrd [2];
  logic [3:0]  mstrb [2];
  logic [1:0]  mresp [2];
  int          vis [2];
  logic [31:0] mmem [2][DEPTH];

  always @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      for (int d = 0; d < 2; d++) begin
        ph[d] = 0; agot[d] = 0; wgot[d] = 0;
      end
    end else begin
      cyc = cyc + 1;
      for (int d = 0; d < 2; d++) begin
        if (ph[d] >= 2) begin
          if (cyc > vis[d] && ((ph[d] == 2 && bready) || (ph[d] == 3 && rready))) begin
            ph[d] = 0;
          end else if (cyc == vis[d]) begin
            mresp[d] = in_rng(maddr[d]) ? 2'b00 : 2'b10;
            if (ph[d] == 2) begin
              if (in_rng(maddr[d]))
                for (int i = 0; i < 4; i++)
                  if (mstrb[d][i]) mmem[d][(maddr[d] - BASE) >> 2][8*i +: 8] = mdata[d][8*i +: 8];
            end else begin
              mrd[d] = in_rng(maddr[d]) ? mmem[d][(maddr[d] - BASE) >> 2] : 32'h0;
            end
          end
        end else begin
          if (awvalid_v[d] && !agot[d]) begin agot[d] = 1; maddr[d] = awaddr; end
          if (wvalid_v[d] && !wgot[d]) begin wgot[d] = 1; mdata[d] = wdata; mstrb[d] = wstrb; end
          if (agot[d] && wgot[d]) begin
            ph[d] = 2; vis[d] = cyc + 1 + ws(d); agot[d] = 0; wgot[d] = 0;
          end else if (agot[d] || wgot[d]) begin
            ph[d] = 1;
          end else if (arvalid_v[d]) begin
            ph[d] = 3; maddr[d] = araddr; vis[d] = cyc + 1 + ws(d);
          end
        end
      end
    end
  end

  logic [31:0] got_rdata [2];
  logic [1:0]  got_rresp [2], got_bresp [2];
  int          b_rise [2];
  logic        b_prev [2] = '{1'b0, 1'b0};

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      logic e_bv, e_rv;
      e_bv = (ph[d] == 2) && (cyc >= vis[d]);
      e_rv = (ph[d] == 3) && (cyc >= vis[d]);
      chk($sformatf("awready%0d@%0d", d, cyc), awready_v[d], (ph[d] <= 1) && !agot[d]);
      chk($sformatf("wready%0d@%0d", d, cyc), wready_v[d], (ph[d] <= 1) && !wgot[d]);
      chk($sformatf("arready%0d@%0d", d, cyc), arready_v[d],
          (ph[d] == 0) && !awvalid_v[d] && !wvalid_v[d]);
      chk($sformatf("bvalid%0d@%0d", d, cyc), bvalid_v[d], e_bv);
      chk($sformatf("rvalid%0d@%0d", d, cyc), rvalid_v[d], e_rv);
      if (e_bv) chk($sformatf("bresp%0d@%0d", d, cyc), bresp_v[d], mresp[d]);
      if (e_rv) begin
        chk($sformatf("rdata%0d@%0d", d, cyc), rdata_v[d], mrd[d]);
        chk($sformatf("rresp%0d@%0d", d, cyc), rresp_v[d], mresp[d]);
      end
      if (rvalid_v[d]) begin got_rdata[d] = rdata_v[d]; got_rresp[d] = rresp_v[d]; end
      if (bvalid_v[d]) got_bresp[d] = bresp_v[d];
      if (bvalid_v[d] && !b_prev[d]) b_rise[d] = cyc;
      b_prev[d] = bvalid_v[d];
    end
  end

  int aw_edge [2];

  task automatic step();
    logic [1:0] ha, hw, hr;
    @(negedge clk);
    ha = awvalid_v & awready_v;
    hw = wvalid_v & wready_v;
    hr = arvalid_v & arready_v;
    @(posedge clk);
    #1;
    awvalid_v = awvalid_v & ~ha;
    wvalid_v  = wvalid_v & ~hw;
    arvalid_v = arvalid_v & ~hr;
    for (int d = 0; d < 2; d++) if (ha[d]) aw_edge[d] = cyc;
  endtask

  task automatic wait_done();
    int n = 0;
    while ((awvalid_v | wvalid_v | arvalid_v) != 2'b00 || ph[0] != 0 || ph[1] != 0) begin
      step();
      n++;
      if (n > 100) begin
        chk("txn_timeout", 32'(n), 32'd0);
        awvalid_v = 0; wvalid_v = 0; arvalid_v = 0;
        break;
      end
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input int lead);
    awaddr = a; wdata = d; wstrb = s;
    wvalid_v = 2'b11;
    repeat (lead) step();
    awvalid_v = 2'b11;
    wait_done();
  endtask

  task automatic rd(input logic [31:0] a);
    araddr = a;
    arvalid_v = 2'b11;
    wait_done();
  endtask

  task automatic chk_rd(input string nm, input logic [31:0] a, input logic [31:0] exp);
    rd(a);
    for (int d = 0; d < 2; d++) chk($sformatf("%s_rdata%0d", nm, d), got_rdata[d], exp);
  endtask

  initial begin
    awaddr = 0; wdata = 0; wstrb = 0; araddr = 0;
    awvalid_v = 0; wvalid_v = 0; arvalid_v = 0;
    bready = 1; rready = 1;
    repeat (2) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("rst_bvalid%0d", d), bvalid_v[d], 0);
      chk($sformatf("rst_rvalid%0d", d), rvalid_v[d], 0);
      chk($sformatf("rst_bresp%0d", d), bresp_v[d], 0);
      chk($sformatf("rst_rresp%0d", d), rresp_v[d], 0);
      chk($sformatf("rst_rdata%0d", d), rdata_v[d], 0);
      chk($sformatf("rst_ready%0d", d), {awready_v[d], wready_v[d], arready_v[d]}, 3'b111);
    end
    @(posedge clk); #1 nreset = 1;

    wr(32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 0);
    chk("t1_blat0", 32'(b_rise[0] - aw_edge[0]), 1);
    chk("t1_blat1", 32'(b_rise[1] - aw_edge[1]), 3);
    chk("t1_bresp0", got_bresp[0], 2'b00);
    chk_rd("t1", 32'h8000_0010, 32'hDEAD_BEEF);
    chk("t1_rresp1", got_rresp[1], 2'b00);

    wr(32'h8000_0020, 32'h1122_3344, 4'hF, 0);
    wr(32'h8000_0020, 32'h0000_AA00, 4'b0010, 0);
    chk_rd("t2", 32'h8000_0020, 32'h1122_AA44);

    wr(32'h8000_0030, 32'hCAFE_F00D, 4'hF, 3);
    chk("t3_blat0", 32'(b_rise[0] - aw_edge[0]), 1);
    chk("t3_blat1", 32'(b_rise[1] - aw_edge[1]), 3);
    chk_rd("t3", 32'h8000_0030, 32'hCAFE_F00D);

    // Read and write offered together: the write must go first.
    awaddr = 32'h8000_0030; wdata = 32'h0BAD_CAFE; wstrb = 4'hF; araddr = 32'h8000_0030;
    awvalid_v = 2'b11; wvalid_v = 2'b11; arvalid_v = 2'b11;
    #2 chk("t4_arready", arready_v, 2'b00);
    wait_done();
    for (int d = 0; d < 2; d++) chk($sformatf("t4_rdata%0d", d), got_rdata[d], 32'h0BAD_CAFE);

    wr(32'h8000_0000, 32'hA5A5_A5A5, 4'hF, 0);
    wr(32'h8000_0FFC, 32'h5A5A_5A5A, 4'hF, 0);
    wr(32'h7FFF_FFFC, 32'hFFFF_FFFF, 4'hF, 0);
    for (int d = 0; d < 2; d++) chk($sformatf("t5_bresp%0d", d), got_bresp[d], 2'b10);
    chk_rd("t5_oor", 32'h8000_1000, 32'h0);
    for (int d = 0; d < 2; d++) chk($sformatf("t5_rresp%0d", d), got_rresp[d], 2'b10);
    chk_rd("t5_w0", 32'h8000_0000, 32'hA5A5_A5A5);
    chk_rd("t5_wlast", 32'h8000_0FFC, 32'h5A5A_5A5A);

    rready = 0;
    araddr = 32'h8000_0020;
    arvalid_v = 2'b11;
    for (int n = 0; n < 20 && arvalid_v != 2'b00; n++) step();
    repeat (6) step();
    chk("t6_rvalid_held", rvalid_v, 2'b11);
    for (int d = 0; d < 2; d++) chk($sformatf("t6_rdata%0d", d), got_rdata[d], 32'h1122_AA44);
    rready = 1;
    wait_done();

    wr(32'h8000_0040, 32'h1234_5678, 4'hF, 0);
    awaddr = 32'h8000_0040; wdata = 32'h55AA_55AA; wstrb = 4'hF;
    awvalid_v = 2'b11; wvalid_v = 2'b11;
    step();
    nreset = 0;
    awvalid_v = 0; wvalid_v = 0;
    #2 chk("t7_bvalid_rst", bvalid_v, 2'b00);
    repeat (2) step();
    nreset = 1;
    chk_rd("t7", 32'h8000_0040, 32'h1234_5678);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not reach its end");
    $fatal(1);
  end

endmodule
